uart_rx_frame_receiver: RTL and testbench



---
 rtl/uart_rx_frame_receiver_if.sv | 43 ++++
 rtl/uart_rx_frame_receiver.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_rx_frame_receiver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_receiver_if.sv
// Purpose: bundles the UART receive line, frame configuration and received-word strobes.
// Latency: none (wiring only).
// Backpressure: none; the receiver only emits one-cycle strobes.
interface uart_rx_frame_receiver_if #(
    parameter int IN_DATA_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 6
);
    // Serial line and per-frame configuration
    logic                      RX_IN;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;

    // Received word and status strobes
    logic [IN_DATA_WIDTH-1:0]  P_DATA;
    logic                      Data_Valid;
    logic                      Par_Err;
    logic                      Stp_Err;

    // Side that drives the line and configuration (stimulus / upstream logic)
    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        output PRESCALE,
        input  P_DATA,
        input  Data_Valid,
        input  Par_Err,
        input  Stp_Err
    );

    // Receiver side
    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        input  PRESCALE,
        output P_DATA,
        output Data_Valid,
        output Par_Err,
        output Stp_Err
    );
endinterface

// File: rtl/uart_rx_frame_receiver.sv
// Purpose: oversampling UART receiver; start, LSB-first data, optional parity, one stop bit.
// Latency: strobes appear 2 sync cycles + vote point of the stop bit + 1 register cycle after the line.
// Backpressure: none; Data_Valid/Par_Err/Stp_Err are single-cycle strobes that must be taken when seen.
module uart_rx_frame_receiver #(
    parameter int IN_DATA_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic                    CLK,
    input logic                    RST,
    uart_rx_frame_receiver_if.slave rx_if
);

    localparam int BCW = (IN_DATA_WIDTH > 1) ? $clog2(IN_DATA_WIDTH) : 1;
    localparam int PW  = PRESCALE_WIDTH;

    localparam logic [BCW-1:0] LAST_BIT = BCW'(IN_DATA_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [PW-1:0]  ONE      = PW'(1);
    localparam logic [PW-1:0]  TWO      = PW'(2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t next_state;

    // Synchronized copy of the asynchronous serial line
    logic rx_meta;
    logic rx_s;

    // IDLE only re-arms after it has seen the line high, so a held-low break
    // cannot be mistaken for a fresh start bit.
    logic armed;

    // Per-frame configuration captured when the start edge is detected
    logic [PW-1:0] p_lat;
    logic          par_en_lat;
    logic          par_typ_lat;

    // Position within the frame
    logic [PW-1:0]  edge_cnt;
    logic [BCW-1:0] bit_cnt;

    // Majority-vote samples; bit_val is the voted bit, valid from the vote point
    logic samp0;
    logic samp1;
    logic bit_val;

    logic [IN_DATA_WIDTH-1:0] shift_reg;
    logic                     frame_err;

    // Sampling points derived from the latched prescale
    logic [PW-1:0] half;
    logic          at_s0;
    logic          at_s1;
    logic          at_s2;
    logic          at_vote;
    logic          at_end;
    logic          exp_par;

    // FSM decode outputs
    logic start_frame;
    logic shift_en;
    logic pe_set;
    logic se_set;
    logic dv_set;

    assign half    = p_lat >> 1;
    assign at_s0   = (edge_cnt == (half - ONE));
    assign at_s1   = (edge_cnt == half);
    assign at_s2   = (edge_cnt == (half + ONE));
    assign at_vote = (edge_cnt == (half + TWO));
    assign at_end  = (edge_cnt == (p_lat - ONE));

    // Parity the transmitter would have generated for the captured word
    assign exp_par = par_typ_lat ? ~^shift_reg : ^shift_reg;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle actions
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        pe_set      = 1'b0;
        se_set      = 1'b0;
        dv_set      = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    next_state  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                // A start bit that votes high was a glitch: drop it silently
                if (at_vote && bit_val) begin
                    next_state = IDLE;
                end else if (at_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_vote) begin
                    shift_en = 1'b1;
                end
                if (at_end && (bit_cnt == LAST_BIT)) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_vote && (bit_val != exp_par)) begin
                    pe_set = 1'b1;
                end
                if (at_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so the next start edge is never missed
                if (at_vote) begin
                    next_state = IDLE;
                    if (!bit_val) begin
                        se_set = 1'b1;
                    end else if (!frame_err) begin
                        dv_set = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Re-arm tracking: set by any high line sample while idle, cleared on leaving idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed <= 1'b0;
        end else if ((state == IDLE) && (next_state == IDLE)) begin
            armed <= armed | rx_s;
        end else begin
            armed <= 1'b0;
        end
    end

    // Frame configuration capture on the start edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_lat       <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
        end else if (start_frame) begin
            p_lat       <= rx_if.PRESCALE;
            par_en_lat  <= rx_if.PAR_EN;
            par_typ_lat <= rx_if.PAR_TYP;
        end
    end

    // Edge and bit counters; the detecting cycle is edge 0 of the start bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_frame) begin
            edge_cnt <= ONE;
            bit_cnt  <= '0;
        end else if (next_state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (at_end) begin
            edge_cnt <= '0;
            if ((state == DATA) && (bit_cnt != LAST_BIT)) begin
                bit_cnt <= bit_cnt + BIT_ONE;
            end else begin
                bit_cnt <= '0;
            end
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Three samples around the bit centre, majority-voted on the third
    always_ff @(posedge CLK) begin
        if (RST) begin
            samp0   <= 1'b1;
            samp1   <= 1'b1;
            bit_val <= 1'b1;
        end else if (state != IDLE) begin
            if (at_s0) begin
                samp0 <= rx_s;
            end
            if (at_s1) begin
                samp1 <= rx_s;
            end
            if (at_s2) begin
                bit_val <= (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
            end
        end
    end

    // Data capture and sticky frame-error flag for the current frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            if (start_frame) begin
                frame_err <= 1'b0;
            end else if (pe_set) begin
                frame_err <= 1'b1;
            end
            if (shift_en) begin
                shift_reg[bit_cnt] <= bit_val;
            end
        end
    end

    // Registered outputs: word is only replaced by a clean frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_if.P_DATA     <= '0;
            rx_if.Data_Valid <= 1'b0;
            rx_if.Par_Err    <= 1'b0;
            rx_if.Stp_Err    <= 1'b0;
        end else begin
            rx_if.Data_Valid <= dv_set;
            rx_if.Par_Err    <= pe_set;
            rx_if.Stp_Err    <= se_set;
            if (dv_set) begin
                rx_if.P_DATA <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Purpose: directed plus randomized frames against a frame-level reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_uart_rx_frame_receiver;

    localparam int W  = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_rx_frame_receiver_if #(.IN_DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

    uart_rx_frame_receiver #(.IN_DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: words expected on Data_Valid, error strobe totals, held word
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           exp_pe = 0;
    int           exp_se = 0;
    logic [W-1:0] model_pdata = '0;

    // Observed strobe activity, counted per high cycle so stretched pulses show up
    int pe_cycles = 0;
    int se_cycles = 0;
    int overlap   = 0;

    always @(negedge CLK) begin
        if (bus.Data_Valid) got_q.push_back(bus.P_DATA);
        if (bus.Par_Err) pe_cycles++;
        if (bus.Stp_Err) se_cycles++;
        if (bus.Data_Valid && (bus.Par_Err || bus.Stp_Err)) overlap++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int len, input int noise_at);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            bus.RX_IN = (i == noise_at) ? ~b : b;
        end
    endtask

    // Drives one frame and records what a correct receiver must report for it
    task automatic send_frame(input logic [W-1:0] d, input int p, input logic pen,
                              input logic ptyp, input logic bad_par, input logic stop_b,
                              input logic noisy);
        logic good_par;
        logic pe;
        int   nz;
        good_par = ptyp ? ~(^d) : (^d);
        nz = noisy ? p / 2 : -1;
        bus.PRESCALE = PW'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        send_bit(1'b0, p, nz);
        for (int i = 0; i < W; i++) send_bit(d[i], p, nz);
        if (pen) send_bit(bad_par ? ~good_par : good_par, p, nz);
        send_bit(stop_b, p, nz);
        pe = pen && bad_par;
        if (pe) exp_pe++;
        if (!stop_b) exp_se++;
        if (stop_b && !pe) begin
            exp_q.push_back(d);
            model_pdata = d;
        end
    endtask

    // Returns the line to idle, lets strobes land, then compares against the model
    task automatic settle_check(input string tag, input int cycles);
        bus.RX_IN = 1'b1;
        repeat (cycles) @(negedge CLK);
        #1;
        chk({tag, ".dv_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, ".dv_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, ".par_err_cycles"}, pe_cycles, exp_pe);
        chk({tag, ".stp_err_cycles"}, se_cycles, exp_se);
        chk({tag, ".dv_err_overlap"}, overlap, 0);
        chk({tag, ".p_data"}, bus.P_DATA, model_pdata);
    endtask

    initial begin
        logic [W-1:0] d;
        int           p;
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.PRESCALE = PW'(8);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset.p_data", bus.P_DATA, 0);
        chk("reset.data_valid", bus.Data_Valid, 0);
        chk("reset.par_err", bus.Par_Err, 0);
        chk("reset.stp_err", bus.Stp_Err, 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Clean even-parity frame
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle_check("even_a5", 8);

        // Odd parity 0x00 then back-to-back no-parity 0xFF
        send_frame(8'h00, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        settle_check("b2b_00_ff", 12);

        // Parity error keeps the previous word
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        settle_check("par_err_3c", 8);

        // Stop error followed by a three-bit-time break
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3 * 8) @(negedge CLK);
        settle_check("stop_break", 40);

        // Glitch rejection, then a real frame at the same prescale
        bus.PRESCALE = PW'(32);
        @(negedge CLK);
        bus.RX_IN = 1'b0;
        repeat (4) @(negedge CLK);
        settle_check("glitch", 80);
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle_check("after_glitch_81", 12);

        // Reset during data bit 3 clears the word without strobes
        d = 8'hB7;
        bus.PRESCALE = PW'(16);
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b0;
        send_bit(1'b0, 16, -1);
        for (int i = 0; i < 3; i++) send_bit(d[i], 16, -1);
        send_bit(d[3], 8, -1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_pdata = '0;
        settle_check("reset_mid", 40);
        send_frame(8'hC3, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle_check("after_reset_c3", 12);

        // Single-clock noise at each bit centre is outvoted
        send_frame(8'h6A, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        settle_check("noise_6a_p16", 12);
        send_frame(8'h93, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle_check("noise_93_p8", 8);

        // Randomized frames against the model
        for (int n = 0; n < 16; n++) begin
            p = 8 << $urandom_range(0, 2);
            d = W'($urandom);
            send_frame(d, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                       1'($urandom_range(0, 1)));
            settle_check("random", 2 * p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
